// File: rtl/dw_fifoctl_2w_2r_s.sv
// dw_fifoctl_2w_2r_s
//   Synchronous FIFO controller for a two-write/two-read flip-flop RAM. Up to two words may be
//   pushed and up to two popped in the same cycle. The controller owns the read/write pointers,
//   the word count and the registered status flags, and drives the RAM port enables/addresses.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   push_cnt, pop_cnt     words requested this cycle (0..2, 3 is illegal)
//   en_w1_n, addr_w1      write port 1: first pushed word at wr_ptr
//   en_w2_n, addr_w2      write port 2: second pushed word at wr_ptr+1
//   en_r1_n, addr_r1      read port 1: FIFO head (rd_ptr), enabled when count >= 1
//   en_r2_n, addr_r2      read port 2: head+1 (rd_ptr+1), enabled when count >= 2
//   word_count            words stored, 0..depth
//   empty, almost_empty, almost_full, full   registered status flags
//   push_ack, pop_ack     request accepted this cycle (combinational)
//   error                 overflow, underflow or illegal count (sticky or pulsed per err_mode)

module dw_fifoctl_2w_2r_s #(
    parameter int unsigned addr_width = 3,
    parameter int unsigned ae_level   = 1,
    parameter int unsigned af_level   = 1,
    parameter int unsigned err_mode   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            push_cnt,
    input  logic [1:0]            pop_cnt,
    output logic                  en_w1_n,
    output logic [addr_width-1:0] addr_w1,
    output logic                  en_w2_n,
    output logic [addr_width-1:0] addr_w2,
    output logic                  en_r1_n,
    output logic [addr_width-1:0] addr_r1,
    output logic                  en_r2_n,
    output logic [addr_width-1:0] addr_r2,
    output logic [addr_width:0]   word_count,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  full,
    output logic                  push_ack,
    output logic                  pop_ack,
    output logic                  error
);

    localparam int unsigned depth = 1 << addr_width;

    localparam logic [addr_width:0]   depth_c = (addr_width+1)'(depth);
    localparam logic [addr_width:0]   ae_c    = (addr_width+1)'(ae_level);
    localparam logic [addr_width:0]   af_c    = (addr_width+1)'(depth - af_level);
    localparam logic [addr_width:0]   two_c   = (addr_width+1)'(2);
    localparam logic [addr_width-1:0] one_a   = addr_width'(1);

    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]   cnt_q, cnt_d;
    logic                  empty_q, almost_empty_q, almost_full_q, full_q, error_q;
    logic                  error_d;

    logic [addr_width:0]   push_n, pop_n, room, push_amt, pop_amt;
    logic                  push_req, pop_req, push_ok, pop_ok, err_now;

    // Accept decisions look only at the count at cycle start; no pass-through.
    always_comb begin
        push_n   = {{(addr_width-1){1'b0}}, push_cnt};
        pop_n    = {{(addr_width-1){1'b0}}, pop_cnt};
        room     = depth_c - cnt_q;
        push_req = (push_cnt == 2'd1) || (push_cnt == 2'd2);
        pop_req  = (pop_cnt == 2'd1) || (pop_cnt == 2'd2);
        push_ok  = push_req && (push_n <= room);
        pop_ok   = pop_req && (pop_n <= cnt_q);
        push_amt = push_ok ? push_n : '0;
        pop_amt  = pop_ok ? pop_n : '0;

        err_now  = (push_cnt == 2'd3) || (pop_cnt == 2'd3)
                || (push_req && !push_ok) || (pop_req && !pop_ok);

        wr_ptr_d = wr_ptr_q + push_amt[addr_width-1:0];
        rd_ptr_d = rd_ptr_q + pop_amt[addr_width-1:0];
        cnt_d    = cnt_q + push_amt - pop_amt;
        error_d  = (err_mode == 0) ? (error_q || err_now) : err_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            full_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            empty_q        <= (cnt_d == '0);
            almost_empty_q <= (cnt_d <= ae_c);
            almost_full_q  <= (cnt_d >= af_c);
            full_q         <= (cnt_d == depth_c);
            error_q        <= error_d;
        end
    end

    // Enables are gated with rst_n so the RAM sees no access while reset is held.
    always_comb begin
        push_ack     = push_ok;
        pop_ack      = pop_ok;
        addr_w1      = wr_ptr_q;
        addr_w2      = wr_ptr_q + one_a;
        en_w1_n      = !(rst_n && push_ok);
        en_w2_n      = !(rst_n && push_ok && (push_cnt == 2'd2));
        addr_r1      = rd_ptr_q;
        addr_r2      = rd_ptr_q + one_a;
        en_r1_n      = !(rst_n && (cnt_q != '0));
        en_r2_n      = !(rst_n && (cnt_q >= two_c));
        word_count   = cnt_q;
        empty        = empty_q;
        almost_empty = almost_empty_q;
        almost_full  = almost_full_q;
        full         = full_q;
        error        = error_q;
    end

endmodule

// File: tb/tb_dw_fifoctl_2w_2r_s.sv
// Bench for dw_fifoctl_2w_2r_s: two instances (sticky and pulsed error) driven by the same
// directed stimulus, checked every cycle against a count/total-based model, plus literal checks.

module tb_dw_fifoctl_2w_2r_s;

    localparam int AW = 3;
    localparam int D  = 8;
    localparam int AE = 1;
    localparam int AF = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    push_cnt, pop_cnt;

    logic          en_w1_n, en_w2_n, en_r1_n, en_r2_n;
    logic [AW-1:0] addr_w1, addr_w2, addr_r1, addr_r2;
    logic [AW:0]   word_count;
    logic          empty, almost_empty, almost_full, full, push_ack, pop_ack, error;

    logic          d1_en_w1_n, d1_en_w2_n, d1_en_r1_n, d1_en_r2_n;
    logic [AW-1:0] d1_addr_w1, d1_addr_w2, d1_addr_r1, d1_addr_r2;
    logic [AW:0]   d1_word_count;
    logic          d1_empty, d1_almost_empty, d1_almost_full, d1_full;
    logic          d1_push_ack, d1_pop_ack, d1_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dw_fifoctl_2w_2r_s #(.addr_width(AW), .ae_level(AE), .af_level(AF), .err_mode(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .push_cnt(push_cnt), .pop_cnt(pop_cnt),
        .en_w1_n(en_w1_n), .addr_w1(addr_w1), .en_w2_n(en_w2_n), .addr_w2(addr_w2),
        .en_r1_n(en_r1_n), .addr_r1(addr_r1), .en_r2_n(en_r2_n), .addr_r2(addr_r2),
        .word_count(word_count), .empty(empty), .almost_empty(almost_empty),
        .almost_full(almost_full), .full(full), .push_ack(push_ack), .pop_ack(pop_ack),
        .error(error)
    );

    dw_fifoctl_2w_2r_s #(.addr_width(AW), .ae_level(AE), .af_level(AF), .err_mode(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .push_cnt(push_cnt), .pop_cnt(pop_cnt),
        .en_w1_n(d1_en_w1_n), .addr_w1(d1_addr_w1), .en_w2_n(d1_en_w2_n),
        .addr_w2(d1_addr_w2), .en_r1_n(d1_en_r1_n), .addr_r1(d1_addr_r1),
        .en_r2_n(d1_en_r2_n), .addr_r2(d1_addr_r2), .word_count(d1_word_count),
        .empty(d1_empty), .almost_empty(d1_almost_empty), .almost_full(d1_almost_full),
        .full(d1_full), .push_ack(d1_push_ack), .pop_ack(d1_pop_ack), .error(d1_error)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: word count, total pushes/pops modulo depth, queue of addresses holding live words.
    int m_cnt = 0, m_wr = 0, m_rd = 0, m_err0 = 0, m_err1 = 0;
    int q[$];

    always @(negedge clk) begin
        int pu, po, pok, qok, err, e_r1, e_r2;
        pu = int'(push_cnt);
        po = int'(pop_cnt);
        if (!rst_n) begin
            chk("rst en_w1_n", en_w1_n, 1);
            chk("rst en_w2_n", en_w2_n, 1);
            chk("rst en_r1_n", en_r1_n, 1);
            chk("rst en_r2_n", en_r2_n, 1);
            chk("rst word_count", word_count, 0);
            chk("rst empty", empty, 1);
            chk("rst almost_empty", almost_empty, 1);
            chk("rst almost_full", almost_full, 0);
            chk("rst full", full, 0);
            chk("rst error0", error, 0);
            chk("rst error1", d1_error, 0);
            m_cnt = 0; m_wr = 0; m_rd = 0; m_err0 = 0; m_err1 = 0;
            q.delete();
        end else begin
            pok = (pu == 1 || pu == 2) && (pu <= D - m_cnt);
            qok = (po == 1 || po == 2) && (po <= m_cnt);
            err = (pu == 3) || (po == 3) || ((pu == 1 || pu == 2) && !pok)
               || ((po == 1 || po == 2) && !qok);
            e_r1 = (q.size() >= 1) ? q[0] : m_rd;
            e_r2 = (q.size() >= 2) ? q[1] : (m_rd + 1) % D;

            chk("push_ack", push_ack, pok);
            chk("pop_ack", pop_ack, qok);
            chk("en_w1_n", en_w1_n, !pok);
            chk("en_w2_n", en_w2_n, !(pok && pu == 2));
            chk("addr_w1", addr_w1, m_wr);
            chk("addr_w2", addr_w2, (m_wr + 1) % D);
            chk("en_r1_n", en_r1_n, !(m_cnt >= 1));
            chk("en_r2_n", en_r2_n, !(m_cnt >= 2));
            chk("addr_r1", addr_r1, e_r1);
            chk("addr_r2", addr_r2, e_r2);
            chk("word_count", word_count, m_cnt);
            chk("empty", empty, m_cnt == 0);
            chk("almost_empty", almost_empty, m_cnt <= AE);
            chk("almost_full", almost_full, m_cnt >= D - AF);
            chk("full", full, m_cnt == D);
            chk("error0", error, m_err0);
            chk("error1", d1_error, m_err1);
            chk("d1 word_count", d1_word_count, m_cnt);
            chk("d1 push_ack", d1_push_ack, pok);

            // Next-state of the model, applied as the coming rising edge will.
            if (qok) begin
                for (int i = 0; i < po; i++) void'(q.pop_front());
                m_rd = (m_rd + po) % D;
                m_cnt -= po;
            end
            if (pok) begin
                for (int i = 0; i < pu; i++) q.push_back((m_wr + i) % D);
                m_wr = (m_wr + pu) % D;
                m_cnt += pu;
            end
            m_err0 = m_err0 | err;
            m_err1 = err;
        end
    end

    // Apply a request just after the edge, then wait to the sampling point.
    task automatic cyc(input logic [1:0] pu, input logic [1:0] po);
        @(posedge clk);
        #1;
        push_cnt = pu;
        pop_cnt  = po;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        push_cnt = 2'd0;
        pop_cnt  = 2'd0;
        @(negedge clk);
        chk("lit rst count", word_count, 0);
        chk("lit rst empty", empty, 1);
        chk("lit rst en_w1_n", en_w1_n, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill with four double pushes.
        for (int i = 0; i < 4; i++) begin
            cyc(2'd2, 2'd0);
            chk("lit fill addr_w1", addr_w1, 2 * i);
            chk("lit fill addr_w2", addr_w2, 2 * i + 1);
            chk("lit fill push_ack", push_ack, 1);
        end
        cyc(2'd1, 2'd0);                        // overflow
        chk("lit full count", word_count, 8);
        chk("lit full flag", full, 1);
        chk("lit full af", almost_full, 1);
        chk("lit ovf push_ack", push_ack, 0);
        chk("lit ovf en_w1_n", en_w1_n, 1);
        cyc(2'd1, 2'd2);                        // full + pop 2 + push 1
        chk("lit ovf error0", error, 1);
        chk("lit ovf count", word_count, 8);
        chk("lit full pop_ack", pop_ack, 1);
        chk("lit full push_rej", push_ack, 0);
        cyc(2'd0, 2'd1);
        chk("lit popfull count", word_count, 6);
        cyc(2'd0, 2'd0);
        chk("lit pre-rst count", word_count, 5);

        // Reset in the middle of traffic.
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("lit mid rst count", word_count, 0);
        chk("lit mid rst addr_r1", addr_r1, 0);
        chk("lit mid rst en_r1_n", en_r1_n, 1);
        chk("lit mid rst error", error, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Bring both pointers to 7, then wrap.
        cyc(2'd2, 2'd0);
        cyc(2'd2, 2'd0);
        cyc(2'd2, 2'd0);
        cyc(2'd1, 2'd0);
        cyc(2'd0, 2'd2);
        chk("lit cnt7 af", almost_full, 1);
        chk("lit cnt7 full", full, 0);
        cyc(2'd0, 2'd2);
        cyc(2'd0, 2'd2);
        cyc(2'd0, 2'd1);
        cyc(2'd2, 2'd0);
        chk("lit wrap addr_w1", addr_w1, 7);
        chk("lit wrap addr_w2", addr_w2, 0);
        cyc(2'd0, 2'd2);
        chk("lit wrap addr_r1", addr_r1, 7);
        chk("lit wrap addr_r2", addr_r2, 0);
        cyc(2'd1, 2'd0);
        chk("lit wrap rd_ptr", addr_r1, 1);

        // cnt=1: pop 2 rejected, push 2 accepted.
        cyc(2'd2, 2'd2);
        chk("lit c1 pop_ack", pop_ack, 0);
        chk("lit c1 push_ack", push_ack, 1);
        cyc(2'd0, 2'd2);
        chk("lit c1 count", word_count, 3);
        chk("lit c1 error1", d1_error, 1);
        cyc(2'd1, 2'd1);
        chk("lit c1b count", word_count, 1);
        chk("lit pulse error1", d1_error, 0);
        cyc(2'd0, 2'd0);
        chk("lit pp count", word_count, 1);
        chk("lit pp empty", empty, 0);
        chk("lit pp ae", almost_empty, 1);
        chk("lit pp error1", d1_error, 0);

        // Illegal counts and underflow.
        cyc(2'd3, 2'd0);
        chk("lit ill push_ack", push_ack, 0);
        cyc(2'd0, 2'd3);
        chk("lit ill error1", d1_error, 1);
        cyc(2'd0, 2'd0);
        chk("lit ill count", word_count, 1);
        cyc(2'd0, 2'd1);
        cyc(2'd0, 2'd1);
        chk("lit udf pop_ack", pop_ack, 0);
        cyc(2'd0, 2'd0);
        chk("lit udf error1", d1_error, 1);
        cyc(2'd0, 2'd0);
        chk("lit udf error1 clr", d1_error, 0);
        chk("lit sticky error0", error, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
